freelist: RTL

- Physical-register free list for rename/dispatch; sits directly upstream of the busy table.
- Supplies up to two free pregs per cycle to rename. Those same pregs drive the busy table's alloc_addr0/1.
- Reclaims up to two stale pregs per cycle from ROB commit.
- Recovers its allocation pointer during ROB overwrite/walk so it stays consistent with the rename table.

---
 rtl/freelist.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/freelist.sv
// freelist: circular physical-register free list feeding rename, refilled by ROB commit,
// with spec_head recovery on ROB overwrite/walk. Define FREELIST_PERF_EN to add perf_stall_cnt.
`ifndef PREG_SIZE
`define PREG_SIZE 64
`endif
`ifndef PREG_RANGE
`define PREG_RANGE 5:0
`endif
`ifndef ROB_STATE_IDLE
`define ROB_STATE_IDLE 2'd0
`endif
`ifndef ROB_STATE_OVERWRITE_RAT
`define ROB_STATE_OVERWRITE_RAT 2'd1
`endif
`ifndef ROB_STATE_WALKING
`define ROB_STATE_WALKING 2'd2
`endif

module freelist #(
    parameter int PREG_NUM = `PREG_SIZE,
    parameter int LREG_NUM = 32,
    parameter int FL_DEPTH = PREG_NUM - LREG_NUM
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        alloc_req0,
    input  logic                        alloc_req1,
    output logic                        alloc_ready,
    output logic [`PREG_RANGE]          alloc_preg0,
    output logic [`PREG_RANGE]          alloc_preg1,
    input  logic                        free_en0,
    input  logic [`PREG_RANGE]          free_preg0,
    input  logic                        free_en1,
    input  logic [`PREG_RANGE]          free_preg1,
    input  logic                        commit_rd_en0,
    input  logic                        commit_rd_en1,
    input  logic [1:0]                  rob_state,
    input  logic                        rob_walk0_valid,
    input  logic                        rob_walk1_valid,
`ifdef FREELIST_PERF_EN
    output logic [31:0]                 perf_stall_cnt,
`endif
    output logic [$clog2(FL_DEPTH):0]   free_count
);

    localparam int IDX_W  = $clog2(FL_DEPTH);
    localparam int PTR_W  = IDX_W + 1;
    localparam int PREG_W = $clog2(PREG_NUM);

    logic [PREG_W-1:0] entry [FL_DEPTH];

    // Pointers carry a wrap bit above the index: equal index with differing wrap means full.
    logic [PTR_W-1:0] spec_head;
    logic [PTR_W-1:0] arch_head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] spec_head_nxt;
    logic [PTR_W-1:0] spec_head_p1;
    logic [PTR_W-1:0] tail_p0;

    logic [PTR_W-1:0] alloc_inc;
    logic [PTR_W-1:0] free_inc;
    logic [PTR_W-1:0] commit_inc;
    logic [PTR_W-1:0] walk_inc;

    logic [IDX_W-1:0] rd_idx0;
    logic [IDX_W-1:0] rd_idx1;
    logic [IDX_W-1:0] wr_idx0;
    logic [IDX_W-1:0] wr_idx1;

    logic is_idle;

    always_comb begin
        alloc_inc  = PTR_W'(alloc_req0) + PTR_W'(alloc_req1);
        free_inc   = PTR_W'(free_en0) + PTR_W'(free_en1);
        commit_inc = PTR_W'(commit_rd_en0) + PTR_W'(commit_rd_en1);
        walk_inc   = PTR_W'(rob_walk0_valid) + PTR_W'(rob_walk1_valid);
    end

    always_comb begin
        spec_head_p1 = spec_head + PTR_W'(1);
        tail_p0      = tail + PTR_W'(free_en0);
        rd_idx0      = spec_head[IDX_W-1:0];
        rd_idx1      = spec_head_p1[IDX_W-1:0];
        wr_idx0      = tail[IDX_W-1:0];
        wr_idx1      = tail_p0[IDX_W-1:0];
    end

    // Ready looks only at registered pointers; a same-cycle free never bypasses into alloc.
    always_comb begin
        is_idle     = (rob_state == `ROB_STATE_IDLE);
        free_count  = tail - spec_head;
        alloc_ready = is_idle && (free_count >= PTR_W'(2));
        alloc_preg0 = entry[rd_idx0];
        alloc_preg1 = entry[rd_idx1];
    end

    // Overwrite restores to the committed point including this cycle's commits.
    always_comb begin
        spec_head_nxt = spec_head;
        case (rob_state)
            `ROB_STATE_OVERWRITE_RAT: spec_head_nxt = arch_head + commit_inc;
            `ROB_STATE_WALKING:       spec_head_nxt = spec_head + walk_inc;
            default: begin
                if (alloc_ready) spec_head_nxt = spec_head + alloc_inc;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            spec_head <= '0;
            arch_head <= '0;
            tail      <= PTR_W'(FL_DEPTH);
        end else begin
            spec_head <= spec_head_nxt;
            arch_head <= arch_head + commit_inc;
            tail      <= tail + free_inc;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                entry[i] <= PREG_W'(LREG_NUM + i);
            end
        end else begin
            if (free_en0) entry[wr_idx0] <= free_preg0;
            if (free_en1) entry[wr_idx1] <= free_preg1;
        end
    end

`ifdef FREELIST_PERF_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_stall_cnt <= '0;
        end else if (is_idle && alloc_req0 && !alloc_ready && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
